// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// architectural constants and a PC alignment helper.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Redirect targets are word aligned by clearing the two low bits.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and holds the fetched word for decode.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;

    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target = align_pc(redirect_pc);
    assign pc_inc = pc_q + PC_STEP;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= RESET_PC;
            inst_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect) begin
                    state_d = imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (imem_ack) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect || !stall) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values; redirect outranks both stall and capture
    always_comb begin
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    pc_d         = target;
                    inst_valid_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        pc_d = target;
                    end else begin
                        // Request already on the bus: park the target until it drains.
                        tgt_d        = target;
                        inst_valid_d = 1'b0;
                    end
                end else if (imem_ack) begin
                    inst_d       = imem_rdata;
                    inst_pc_d    = pc_q;
                    pc_d         = pc_inc;
                    inst_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d         = target;
                    inst_valid_d = 1'b0;
                end else if (!stall) begin
                    inst_valid_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    tgt_d = target;
                end
                if (imem_ack) begin
                    pc_d = redirect ? target : tgt_q;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Outputs: registers and state decode only
    always_comb begin
        imem_req   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        imem_addr  = pc_q;
        inst       = inst_q;
        inst_pc    = inst_pc_q;
        inst_valid = inst_valid_q;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RISC-V core: owns the program counter, runs a request/acknowledge handshake with instruction memory, and holds the fetched word in an instruction register. The register's `inst[31:0]` output drives the decoder and the immediate extender directly, so `inst` stays stable for as long as the consumer stalls. Taken branches and jumps redirect the PC through a single redirect port.

## Interface
- `RESET_PC`, default 32'h0000_0000, address of the first fetch after reset.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request; held high until acknowledged.
- `imem_addr` output 32: fetch address; stable while `imem_req` is high.
- `imem_ack` input 1: memory response valid; ignored while `imem_req` is low.
- `imem_rdata` input 32: instruction word, captured on the `imem_ack` edge.
- `stall` input 1: consumer not ready; the held instruction is kept.
- `redirect` input 1: branch/jump taken.
- `redirect_pc` input 32: target address; bits [1:0] are forced to 0.
- `inst` output 32: held instruction, fed to decode and the immediate extender.
- `inst_pc` output 32: address of `inst`.
- `inst_valid` output 1: `inst` is a live instruction.

## Operation
- Reset values (asynchronous):
  - `pc` = `RESET_PC`; `imem_addr` = `RESET_PC`.
  - `imem_req` = 0; `inst_valid` = 0.
  - `inst` = 32'h0000_0013 (NOP); `inst_pc` = `RESET_PC`.
  - State = IDLE; the latched redirect target = 0.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: lasts exactly 1 cycle after reset release; next state FETCH.
- FETCH: `imem_req` = 1, `imem_addr` = `pc`.
  - `imem_ack` without `redirect`: `inst` <= `imem_rdata`, `inst_pc` <= `pc`, `pc` <= `pc`+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), `inst_valid` <= 1, next state HOLD.
- HOLD: `imem_req` = 0; `inst`, `inst_pc` and `inst_valid` are frozen while `stall` = 1.
  - `stall` = 0: the instruction is consumed on that edge; `inst_valid` <= 0, next state FETCH.
- Redirect has priority over `stall` and over the capture.
  - IDLE or HOLD: `pc` <= target, `inst_valid` <= 0, next state FETCH.
  - FETCH with `imem_ack` in the same cycle: the response is discarded, `pc` <= target, next state FETCH; `inst` and `inst_valid` are unchanged.
  - FETCH without `imem_ack`: the target is latched, `inst_valid` <= 0, next state DRAIN. The outstanding request is never withdrawn.
- DRAIN: `imem_req` = 1 with the old address.
  - A new `redirect` overwrites the latched target.
  - On `imem_ack`: the data is discarded, `pc` <= latched target (or the new `redirect_pc` if asserted that cycle), next state FETCH.
- `inst` is never altered except by a capture or by reset.
- Reset asserted mid-handshake drops `imem_req` asynchronously. Memory must tolerate an abandoned request.

## Timing
- Latency: `imem_ack` in the first FETCH cycle makes `inst_valid` = 1 on the next edge.
- Peak throughput: 1 instruction per 2 cycles with a zero-wait memory (FETCH, then HOLD).
- Each wait state adds 1 cycle; `imem_addr` is constant throughout.
- A redirect applies one edge after assertion. The first request to the target goes out in the following cycle, or after the drain completes.
- All outputs are registered or decoded from state only; there is no combinational path from `imem_*` inputs to outputs.

## Structure
- Shared core package contents:
  - State enumeration (2-bit).
  - `NOP_INST` = 32'h0000_0013.
  - `PC_STEP` = 4.
  - The default `RESET_PC`.
- Single module; no sub-module required.
- The PC incrementer is inline. The latched redirect target is a local 32-bit register.

## Test plan
- **Reset, zero-wait memory.** Reset, then `imem_ack` high on the first FETCH with `imem_rdata`=32'h0050_0093 → `inst`=32'h0050_0093, `inst_pc`=0, `inst_valid`=1, `pc`=4.
- **Stall hold.** `stall`=1 for 5 cycles in HOLD → `inst` and `inst_pc` unchanged, `imem_req`=0. Release `stall` → next request addr=4.
- **Wait states.** `imem_ack` delayed 3 cycles → `imem_addr` stays 4 for all 4 cycles of `imem_req`. An `imem_ack` pulse while `imem_req`=0 is ignored.
- **Redirect during drain.** `redirect`=1 with `redirect_pc`=32'h0000_0102 in FETCH before ack → DRAIN. The later ack's data is discarded, `inst_valid`=0, next `imem_addr`=32'h0000_0100.
- **Simultaneous events.** `redirect` with `imem_ack` in the same cycle → data is not captured, next addr = target. `redirect` with `stall`=1 in HOLD → `inst_valid` drops and the fetch restarts.
- **Wrap and reset mid-handshake.** Redirect to 32'hFFFF_FFFC, then capture → `pc` wraps to 0. Assert `rst_n`=0 mid-FETCH → `imem_req`=0 immediately and `inst`=NOP.
